im_cache_nway: RTL and testbench

- Parametrised N-way set-associative instruction cache with an integrated miss handler.
- It owns refill: on a miss it fetches the line from memory over a req/ack handshake and picks the victim way itself (first invalid way, else per-set round-robin).
- It sits between the fetch stage and instruction memory, and it supports a whole-cache invalidate.
- Defaults give 2 sets x 8 ways, 512-bit lines and a 25-bit tag.

---
 rtl/im_cache_nway_if.sv | 28 ++
 rtl/im_cache_nway.sv | 156 +++++++++++++++
 tb/tb_im_cache_nway.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/im_cache_nway_if.sv
// Fetch-side and refill-side signals of the N-way instruction cache.
// The cache takes the slave view; the fetch stage and memory take the master view.
interface im_cache_nway_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 512
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ready;
  logic              cpu_valid;
  logic [31:0]       cpu_word;
  logic              cache_hit;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_line;

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_ack, mem_line,
    output cpu_ready, cpu_valid, cpu_word, cache_hit, mem_req, mem_addr
  );

  modport master (
    output cpu_req, cpu_addr, flush, mem_ack, mem_line,
    input  cpu_ready, cpu_valid, cpu_word, cache_hit, mem_req, mem_addr
  );
endinterface

// File: rtl/im_cache_nway.sv
// N-way set-associative instruction cache with built-in refill and victim selection.
//   state | meaning
//   IDLE  | accept lookups/flush; hits answered next cycle
//   MISS  | mem_req held, waiting for mem_ack
//   RESP  | one cycle presenting the refilled word
module im_cache_nway #(
  parameter int ADDR_W     = 32,
  parameter int NUM_SETS   = 2,
  parameter int NUM_WAYS   = 8,
  parameter int LINE_WORDS = 16
)(
  input logic            clk,
  input logic            reset,
  im_cache_nway_if.slave bus
);
  localparam int LINE_W = 32 * LINE_WORDS;
  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int SEL_W  = OFF_W - 2;

  typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;
  state_t state, stateNext;

  logic              validArr [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]  tagArr   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0] dataArr  [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]  rrPtr    [NUM_SETS];

  logic [TAG_W-1:0] reqTag, inTag;
  logic [IDX_W-1:0] reqIdx, inIdx;
  logic [SEL_W-1:0] reqSel, inSel;
  logic [1:0]       unusedAddrBits;

  logic             hitAny, freeAny;
  logic [WAY_W-1:0] hitWay, freeWay, victim;
  logic [31:0]      hitWord, fillWord;
  logic             doFlush, doHit, doMiss, doFill;

  assign inTag          = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign inIdx          = bus.cpu_addr[OFF_W +: IDX_W];
  assign inSel          = bus.cpu_addr[OFF_W-1:2];
  assign unusedAddrBits = bus.cpu_addr[1:0];

  // Scan downward so the lowest-numbered matching way wins.
  always_comb begin
    hitAny = 1'b0;
    hitWay = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (validArr[inIdx][w] && (tagArr[inIdx][w] == inTag)) begin
        hitAny = 1'b1;
        hitWay = WAY_W'(w);
      end
    end
  end

  always_comb begin
    freeAny = 1'b0;
    freeWay = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!validArr[reqIdx][w]) begin
        freeAny = 1'b1;
        freeWay = WAY_W'(w);
      end
    end
    victim = freeAny ? freeWay : rrPtr[reqIdx];
  end

  assign hitWord  = dataArr[inIdx][hitWay][{inSel, 5'b0} +: 32];
  assign fillWord = bus.mem_line[{reqSel, 5'b0} +: 32];

  assign bus.cpu_ready = (state == IDLE) && !bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    doFlush   = 1'b0;
    doHit     = 1'b0;
    doMiss    = 1'b0;
    doFill    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.flush) begin
          doFlush = 1'b1;
        end else if (bus.cpu_req) begin
          if (hitAny) begin
            doHit = 1'b1;
          end else begin
            doMiss    = 1'b1;
            stateNext = MISS;
          end
        end
      end
      MISS: begin
        if (bus.mem_ack) begin
          doFill    = 1'b1;
          stateNext = RESP;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cpu_valid <= 1'b0;
      bus.cache_hit <= 1'b0;
      bus.cpu_word  <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= '0;
      reqTag        <= '0;
      reqIdx        <= '0;
      reqSel        <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        rrPtr[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) validArr[s][w] <= 1'b0;
      end
    end else begin
      bus.cpu_valid <= doHit || doFill;
      bus.cache_hit <= doHit;
      if (doHit) bus.cpu_word <= hitWord;
      if (doMiss) begin
        reqTag       <= inTag;
        reqIdx       <= inIdx;
        reqSel       <= inSel;
        bus.mem_req  <= 1'b1;
        bus.mem_addr <= {inTag, inIdx, {OFF_W{1'b0}}};
      end
      if (doFill) begin
        bus.mem_req              <= 1'b0;
        bus.cpu_word             <= fillWord;
        validArr[reqIdx][victim] <= 1'b1;
        // Pointer only advances when a valid line is evicted.
        if (!freeAny) rrPtr[reqIdx] <= rrPtr[reqIdx] + 1'b1;
      end
      if (doFlush) begin
        for (int s = 0; s < NUM_SETS; s++)
          for (int w = 0; w < NUM_WAYS; w++) validArr[s][w] <= 1'b0;
      end
    end
  end

  // Tag/data need no reset: they are only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (doFill) begin
      tagArr[reqIdx][victim]  <= reqTag;
      dataArr[reqIdx][victim] <= bus.mem_line;
    end
  end
endmodule

// File: tb/tb_im_cache_nway.sv
// Self-checking bench for im_cache_nway: directed vector table, hand-written corner
// sequences and randomized accesses checked against a set/way occupancy model.
module tb_im_cache_nway;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  im_cache_nway_if #(.ADDR_W(32), .LINE_W(512)) bus ();

  im_cache_nway #(.ADDR_W(32), .NUM_SETS(2), .NUM_WAYS(8), .LINE_WORDS(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int passed = 0;

  // Reference model: per set, which tags are resident and where the next eviction lands.
  bit          mValid [2][8];
  logic [24:0] mTag   [2][8];
  int          mPtr   [2];

  typedef struct {
    logic [31:0] addr;
    logic        expHit;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_0084) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [511:0] makeLine(input logic [31:0] lineAddr);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = memWord(lineAddr + 32'(i * 4));
    return l;
  endfunction

  function automatic void modelReset();
    for (int s = 0; s < 2; s++) begin
      mPtr[s] = 0;
      for (int w = 0; w < 8; w++) begin mValid[s][w] = 0; mTag[s][w] = '0; end
    end
  endfunction

  function automatic void modelFlush();
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 8; w++) mValid[s][w] = 0;
  endfunction

  // Returns whether the access hits; on a miss, records where the line goes.
  function automatic logic modelLookup(input logic [31:0] a);
    int s;
    logic [24:0] t;
    logic found;
    int slot;
    s = int'(a[6]);
    t = a[31:7];
    found = 1'b0;
    for (int w = 0; w < 8; w++) if (mValid[s][w] && mTag[s][w] == t) found = 1'b1;
    if (found) return 1'b1;
    slot = -1;
    for (int w = 7; w >= 0; w--) if (!mValid[s][w]) slot = w;
    if (slot < 0) begin
      slot = mPtr[s];
      mPtr[s] = (mPtr[s] + 1) % 8;
    end
    mValid[s][slot] = 1;
    mTag[s][slot] = t;
    return 1'b0;
  endfunction

  task automatic waitReady();
    int n = 0;
    @(negedge clk);
    while (!bus.cpu_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.cpu_ready) check("readyTimeout", 32'd0, 32'd1);
  endtask

  task automatic access(input logic [31:0] addr, input logic expHit, input int ackDelay);
    logic done = 1'b0;
    logic sawMem = 1'b0;
    logic gotHit = 1'b0;
    logic [31:0] gotWord = '0;
    logic [31:0] mAddr = '0;
    int cycles = 0;
    int waitLeft = ackDelay;
    logic [31:0] lineA = {addr[31:6], 6'b0};
    logic [31:0] expWord = memWord({addr[31:2], 2'b00});
    waitReady();
    bus.cpu_req = 1'b1;
    bus.cpu_addr = addr;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      bus.mem_ack = 1'b0;
      if (bus.cpu_valid) begin
        done = 1'b1; gotHit = bus.cache_hit; gotWord = bus.cpu_word; cycles = c;
      end else begin
        if (bus.mem_req) begin
          if (!sawMem) mAddr = bus.mem_addr;
          sawMem = 1'b1;
          if (waitLeft == 0) begin
            bus.mem_ack = 1'b1;
            bus.mem_line = makeLine(bus.mem_addr);
          end else waitLeft--;
        end
        @(posedge clk); #1;
      end
    end
    bus.mem_ack = 1'b0;
    check("respTimeout", 32'(done), 32'd1);
    if (done) begin
      check("hitFlag", 32'(gotHit), 32'(expHit));
      check("word", gotWord, expWord);
      check("memReqSeen", 32'(sawMem), 32'(!expHit));
      if (sawMem) check("memAddr", mAddr, lineA);
      if (expHit) check("hitLatency", 32'(cycles), 32'd0);
      else        check("missLatency", 32'(cycles), 32'(ackDelay + 1));
      @(posedge clk); #1;
      check("validPulse", 32'(bus.cpu_valid), 32'd0);
      check("hitPulse", 32'(bus.cache_hit), 32'd0);
      check("wordHold", bus.cpu_word, expWord);
    end
  endtask

  task automatic doFlush();
    waitReady();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    modelFlush();
  endtask

  initial begin
    logic [31:0] addr;
    logic h;
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    bus.cpu_addr = '0;
    bus.flush = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_line = '0;
    modelReset();

    vecs.push_back('{32'h0000_0084, 1'b0});
    vecs.push_back('{32'h0000_0088, 1'b1});
    vecs.push_back('{32'h0000_00BC, 1'b1});
    vecs.push_back('{32'h0000_0040, 1'b0});
    vecs.push_back('{32'h0000_0000, 1'b0});
    vecs.push_back('{32'h0000_0044, 1'b1});
    vecs.push_back('{32'h0000_0004, 1'b1});
    vecs.push_back('{32'h0000_0084, 1'b1});
    for (int k = 2; k < 8; k++) vecs.push_back('{32'(k * 128), 1'b0});
    vecs.push_back('{32'h0000_0400, 1'b0});
    vecs.push_back('{32'h0000_0080, 1'b0});
    vecs.push_back('{32'h0000_0000, 1'b0});
    vecs.push_back('{32'h0000_0180, 1'b1});
    vecs.push_back('{32'h0000_0100, 1'b0});
    vecs.push_back('{32'h0000_0400, 1'b1});
    vecs.push_back('{32'h0000_0384, 1'b1});

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstValid", 32'(bus.cpu_valid), 32'd0);
    check("rstHit", 32'(bus.cache_hit), 32'd0);
    check("rstWord", bus.cpu_word, 32'd0);
    check("rstMemReq", 32'(bus.mem_req), 32'd0);
    check("rstMemAddr", bus.mem_addr, 32'd0);
    check("rstReady", 32'(bus.cpu_ready), 32'd1);

    foreach (vecs[i]) begin
      void'(modelLookup(vecs[i].addr));
      access(vecs[i].addr, vecs[i].expHit, i % 3);
    end

    // Back-to-back hits on the resident 0x80 line: one word per cycle.
    waitReady();
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 32'h0000_0088;
    @(posedge clk); #1;
    bus.cpu_addr = 32'h0000_00BC;
    check("b2bValid0", 32'(bus.cpu_valid), 32'd1);
    check("b2bHit0", 32'(bus.cache_hit), 32'd1);
    check("b2bWord0", bus.cpu_word, memWord(32'h0000_0088));
    check("b2bMemReq0", 32'(bus.mem_req), 32'd0);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    check("b2bValid1", 32'(bus.cpu_valid), 32'd1);
    check("b2bHit1", 32'(bus.cache_hit), 32'd1);
    check("b2bWord1", bus.cpu_word, memWord(32'h0000_00BC));
    check("b2bMemReq1", 32'(bus.mem_req), 32'd0);
    @(posedge clk); #1;
    check("b2bEnd", 32'(bus.cpu_valid), 32'd0);

    // Flush with a simultaneous request: request refused, then everything misses.
    waitReady();
    bus.flush = 1'b1;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 32'h0000_0084;
    #1;
    check("flushReady", 32'(bus.cpu_ready), 32'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.cpu_req = 1'b0;
    check("flushNoValid", 32'(bus.cpu_valid), 32'd0);
    check("flushNoMemReq", 32'(bus.mem_req), 32'd0);
    modelFlush();
    void'(modelLookup(32'h0000_0084));
    access(32'h0000_0084, 1'b0, 1);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 12) == 0) begin
        doFlush();
      end else begin
        addr = (32'($urandom_range(0, 11)) << 7) | (32'($urandom_range(0, 1)) << 6)
             | (32'($urandom_range(0, 15)) << 2);
        h = modelLookup(addr);
        access(addr, h, int'($urandom_range(0, 3)));
      end
    end

    // Reset in the middle of a refill abandons it.
    waitReady();
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 32'h1000_0000;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    check("midMissReq", 32'(bus.mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rstAsyncDrop", 32'(bus.mem_req), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    modelReset();
    bus.mem_ack = 1'b1;
    bus.mem_line = makeLine(32'h1000_0000);
    @(posedge clk); #1;
    check("lateAckValid", 32'(bus.cpu_valid), 32'd0);
    check("lateAckReady", 32'(bus.cpu_ready), 32'd1);
    bus.mem_ack = 1'b0;
    void'(modelLookup(32'h1000_0004));
    access(32'h1000_0004, 1'b0, 0);
    void'(modelLookup(32'h0000_0084));
    access(32'h0000_0084, 1'b0, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
